// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, streams sequential imem reads and hands {instr, pc} to decode.
// Optional static JAL prediction is enabled by defining FETCH_STATIC_PREDICT_EN.
module instr_fetch_unit #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [WIDTH-1:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic [WIDTH-1:0] imem_rdata,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_target,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic [WIDTH-1:0] instr_out,
  output logic [WIDTH-1:0] pc_out,
  output logic             pred_taken,
  output logic             misalign_err
);

  typedef enum logic [1:0] {BOOT, FETCH, HALT} state_t;

  localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(4);

  state_t           state_q, state_next;
  logic [WIDTH-1:0] pc_q, pc_next;
  logic             out_valid_q, out_valid_next;
  logic [WIDTH-1:0] out_instr_q, out_instr_next;
  logic [WIDTH-1:0] out_pc_q, out_pc_next;
  logic             out_pred_q, out_pred_next;
  logic             skid_valid_q, skid_valid_next;
  logic [WIDTH-1:0] skid_instr_q, skid_instr_next;
  logic [WIDTH-1:0] skid_pc_q, skid_pc_next;
  logic             infl_q, infl_next;
  logic [WIDTH-1:0] infl_pc_q, infl_pc_next;
  logic             err_q, err_next;

  logic             accept;
  logic             enter;
  logic             enter_from_skid;
  logic [WIDTH-1:0] enter_instr;
  logic [WIDTH-1:0] enter_pc;
  logic [1:0]       occ;

`ifdef FETCH_STATIC_PREDICT_EN
  logic             pend_q, pend_next;
  logic [WIDTH-1:0] pend_target_q, pend_target_next;
  logic [WIDTH-1:0] jimm;
  assign jimm = {{(WIDTH-20){enter_instr[31]}}, enter_instr[19:12], enter_instr[20],
                 enter_instr[30:21], 1'b0};
`endif

  assign accept          = out_valid_q & instr_ready;
  // Whatever lands in the output slot this edge: skid first (older), else the response.
  assign enter_from_skid = accept & skid_valid_q;
  assign enter           = (state_q == FETCH) &
                           (enter_from_skid | (infl_q & (accept | ~out_valid_q)));
  assign enter_instr     = enter_from_skid ? skid_instr_q : imem_rdata;
  assign enter_pc        = enter_from_skid ? skid_pc_q : infl_pc_q;
  // Entries held after this cycle's handshake; a new request may raise it to 2 at most.
  assign occ = 2'(out_valid_q) + 2'(skid_valid_q) + 2'(infl_q) - 2'(accept);

  always_comb begin
    state_next      = state_q;
    pc_next         = pc_q;
    imem_req        = 1'b0;
    imem_addr       = pc_q;
    out_valid_next  = out_valid_q;
    out_instr_next  = out_instr_q;
    out_pc_next     = out_pc_q;
    out_pred_next   = out_pred_q;
    skid_valid_next = skid_valid_q;
    skid_instr_next = skid_instr_q;
    skid_pc_next    = skid_pc_q;
    infl_next       = 1'b0;
    infl_pc_next    = infl_pc_q;
    err_next        = err_q;
`ifdef FETCH_STATIC_PREDICT_EN
    pend_next        = 1'b0;
    pend_target_next = pend_target_q;
`endif
    case (state_q)
      BOOT: state_next = FETCH;
      FETCH: begin
        if (enter) begin
          out_valid_next = 1'b1;
          out_instr_next = enter_instr;
          out_pc_next    = enter_pc;
          out_pred_next  = 1'b0;
        end else if (accept) begin
          out_valid_next = 1'b0;
        end
        if (enter_from_skid) skid_valid_next = 1'b0;
        if (infl_q && out_valid_q && (!accept || skid_valid_q)) begin
          skid_valid_next = 1'b1;
          skid_instr_next = imem_rdata;
          skid_pc_next    = infl_pc_q;
        end
        if (occ < 2'd2) begin
          imem_req     = 1'b1;
          pc_next      = pc_q + PC_STEP;
          infl_next    = 1'b1;
          infl_pc_next = pc_q;
        end
`ifdef FETCH_STATIC_PREDICT_EN
        if (enter && enter_instr[6:0] == 7'b1101111) begin
          out_pred_next    = 1'b1;
          pend_next        = 1'b1;
          pend_target_next = enter_pc + jimm;
        end
        // Predicted redirect: the JAL itself stays in the output slot, younger work dies.
        if (pend_q) begin
          pend_next       = 1'b0;
          out_valid_next  = out_valid_q & ~accept;
          out_instr_next  = out_instr_q;
          out_pc_next     = out_pc_q;
          out_pred_next   = out_pred_q;
          skid_valid_next = 1'b0;
          if (pend_target_q[1:0] != 2'b00) begin
            imem_req       = 1'b0;
            pc_next        = pc_q;
            infl_next      = 1'b0;
            out_valid_next = 1'b0;
            err_next       = 1'b1;
            state_next     = HALT;
          end else begin
            imem_req     = 1'b1;
            imem_addr    = pend_target_q;
            pc_next      = pend_target_q + PC_STEP;
            infl_next    = 1'b1;
            infl_pc_next = pend_target_q;
          end
        end
`endif
      end
      default: begin
        out_valid_next  = 1'b0;
        skid_valid_next = 1'b0;
      end
    endcase

    // External redirect overrides everything decided above.
    if (redirect_valid && state_q != HALT && !rst) begin
      out_valid_next  = 1'b0;
      out_instr_next  = out_instr_q;
      out_pc_next     = out_pc_q;
      out_pred_next   = out_pred_q;
      skid_valid_next = 1'b0;
`ifdef FETCH_STATIC_PREDICT_EN
      pend_next       = 1'b0;
`endif
      if (redirect_target[1:0] == 2'b00) begin
        imem_req     = 1'b1;
        imem_addr    = redirect_target;
        pc_next      = redirect_target + PC_STEP;
        infl_next    = 1'b1;
        infl_pc_next = redirect_target;
        state_next   = FETCH;
      end else begin
        imem_req   = 1'b0;
        imem_addr  = pc_q;
        pc_next    = pc_q;
        infl_next  = 1'b0;
        err_next   = 1'b1;
        state_next = HALT;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= BOOT;
      pc_q         <= RESET_PC;
      out_valid_q  <= 1'b0;
      out_instr_q  <= NOP_INSTR;
      out_pc_q     <= RESET_PC;
      out_pred_q   <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_instr_q <= NOP_INSTR;
      skid_pc_q    <= RESET_PC;
      infl_q       <= 1'b0;
      infl_pc_q    <= RESET_PC;
      err_q        <= 1'b0;
`ifdef FETCH_STATIC_PREDICT_EN
      pend_q        <= 1'b0;
      pend_target_q <= RESET_PC;
`endif
    end else begin
      state_q      <= state_next;
      pc_q         <= pc_next;
      out_valid_q  <= out_valid_next;
      out_instr_q  <= out_instr_next;
      out_pc_q     <= out_pc_next;
      out_pred_q   <= out_pred_next;
      skid_valid_q <= skid_valid_next;
      skid_instr_q <= skid_instr_next;
      skid_pc_q    <= skid_pc_next;
      infl_q       <= infl_next;
      infl_pc_q    <= infl_pc_next;
      err_q        <= err_next;
`ifdef FETCH_STATIC_PREDICT_EN
      pend_q        <= pend_next;
      pend_target_q <= pend_target_next;
`endif
    end
  end

  assign instr_valid  = out_valid_q;
  assign instr_out    = out_valid_q ? out_instr_q : NOP_INSTR;
  assign pc_out       = out_pc_q;
  assign pred_taken   = out_valid_q & out_pred_q;
  assign misalign_err = err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus a randomized
// ready/redirect stream checked against an in-order program-flow reference.
`timescale 1ns/1ps
module tb_instr_fetch_unit;
  localparam int          W        = 32;
  localparam logic [W-1:0] RST_PC   = 32'h0000_0000;
  localparam logic [W-1:0] NOP      = 32'h0000_0013;
  localparam logic [W-1:0] JAL_WORD = 32'h0400_006F;  // jal x0, +0x40

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         imem_req;
  logic [W-1:0] imem_addr;
  logic [W-1:0] imem_rdata = '0;
  logic         redirect_valid = 1'b0;
  logic [W-1:0] redirect_target = '0;
  logic         instr_valid;
  logic         instr_ready = 1'b0;
  logic [W-1:0] instr_out;
  logic [W-1:0] pc_out;
  logic         pred_taken;
  logic         misalign_err;

  int           compared = 0;
  int           mismatched = 0;
  logic         jal_on = 1'b0;
  logic [W-1:0] exp_pc;

  instr_fetch_unit dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_out(instr_out), .pc_out(pc_out),
    .pred_taken(pred_taken), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  // Memory image: each word holds its own address, optionally a JAL at 0x8.
  function automatic logic [W-1:0] mem_word(input logic [W-1:0] a);
    if (jal_on && a == 32'h8) return JAL_WORD;
    return a;
  endfunction

  always @(posedge clk) if (imem_req) imem_rdata <= mem_word(imem_addr);

  task automatic apply_reset(input logic rdy);
    rst = 1'b1; redirect_valid = 1'b0; redirect_target = '0; instr_ready = rdy;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (n < 20) begin
      @(posedge clk); #2;
      n++;
      if (instr_valid) break;
    end
  endtask

  task automatic test_reset();
    logic [3*W+3:0] got, want;
    int n;
    rst = 1'b1; instr_ready = 1'b1; redirect_valid = 1'b0;
    @(posedge clk); #3;
    got  = {imem_req, imem_addr, instr_valid, instr_out, pc_out, pred_taken, misalign_err};
    want = {1'b0, RST_PC, 1'b0, NOP, RST_PC, 1'b0, 1'b0};
    compared++;
    if (got !== want) begin mismatched++; $display("FAIL reset_values: got %h expected %h", got, want); end
    @(posedge clk); #2; rst = 1'b0; #1;
    compared++;
    if (imem_req !== 1'b0) begin mismatched++; $display("FAIL boot_no_req: got %b expected 0", imem_req); end
    wait_valid(n);
    compared++;
    if (n != 3 || instr_valid !== 1'b1) begin
      mismatched++; $display("FAIL first_valid_latency: got %0d cycles (valid=%b) expected 3", n, instr_valid);
    end
  endtask

  task automatic test_stream();
    int n;
    apply_reset(1'b1); wait_valid(n);
    compared++;
    if (instr_valid !== 1'b1) begin mismatched++; $display("FAIL stream_timeout: got valid=%b expected 1", instr_valid); end
    exp_pc = RST_PC;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) begin @(posedge clk); #2; end
      compared++;
      if ({instr_valid, pc_out, instr_out} !== {1'b1, exp_pc, mem_word(exp_pc)}) begin
        mismatched++; $display("FAIL stream_seq: got v=%b pc=%h instr=%h expected pc=%h", instr_valid, pc_out, instr_out, exp_pc);
      end
      $display("[%0t] stream accept pc=%h instr=%h", $time, pc_out, instr_out);
      exp_pc += 4;
    end
  endtask

  task automatic test_stall();
    int n;
    apply_reset(1'b1); wait_valid(n);
    compared++;
    if (instr_valid !== 1'b1) begin mismatched++; $display("FAIL stall_timeout: got valid=%b expected 1", instr_valid); end
    exp_pc = RST_PC;
    for (int i = 0; i < 20; i++) begin
      if (i > 0) begin @(posedge clk); #1; instr_ready = !(i >= 4 && i < 9); #1; end
      compared++;
      if (instr_valid !== 1'b1) begin mismatched++; $display("FAIL stall_gap: got valid=%b expected 1", instr_valid); end
      if (!instr_ready) begin
        compared++;
        if ({imem_req, pc_out, instr_out} !== {1'b0, exp_pc, mem_word(exp_pc)}) begin
          mismatched++; $display("FAIL stall_freeze: got req=%b pc=%h instr=%h expected req=0 pc=%h", imem_req, pc_out, instr_out, exp_pc);
        end
      end else begin
        compared++;
        if ({pc_out, instr_out} !== {exp_pc, mem_word(exp_pc)}) begin
          mismatched++; $display("FAIL stall_order: got pc=%h instr=%h expected pc=%h", pc_out, instr_out, exp_pc);
        end
        $display("[%0t] stall accept pc=%h instr=%h", $time, pc_out, instr_out);
        exp_pc += 4;
      end
    end
    instr_ready = 1'b1;
  endtask

  // Skid-full redirect to 0x100, then a redirect that wraps the PC past 2^32.
  task automatic test_redirect();
    int n;
    int since;
    apply_reset(1'b1); wait_valid(n);
    compared++;
    if (instr_valid !== 1'b1) begin mismatched++; $display("FAIL redir_timeout: got valid=%b expected 1", instr_valid); end
    exp_pc = RST_PC; since = 1;
    for (int i = 0; i < 22; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
        instr_ready = !(i >= 3 && i <= 5);
        redirect_valid = (i == 5 || i == 12);
        redirect_target = (i == 5) ? 32'h0000_0100 : 32'hFFFF_FFF8;
        #1;
      end
      since++;
      if (since == 1) begin
        compared++;
        if (instr_valid !== 1'b0) begin mismatched++; $display("FAIL redir_bubble: got valid=%b expected 0", instr_valid); end
      end else begin
        compared++;
        if (instr_valid !== 1'b1) begin mismatched++; $display("FAIL redir_gap: got valid=%b expected 1", instr_valid); end
      end
      if (instr_valid && instr_ready) begin
        compared++;
        if ({pc_out, instr_out, pred_taken} !== {exp_pc, mem_word(exp_pc), 1'b0}) begin
          mismatched++; $display("FAIL redir_order: got pc=%h instr=%h pred=%b expected pc=%h", pc_out, instr_out, pred_taken, exp_pc);
        end
        $display("[%0t] redirect-test accept pc=%h instr=%h", $time, pc_out, instr_out);
        exp_pc += 4;
      end
      if (redirect_valid) begin
        compared++;
        if ({imem_req, imem_addr} !== {1'b1, redirect_target}) begin
          mismatched++; $display("FAIL redir_req: got req=%b addr=%h expected req=1 addr=%h", imem_req, imem_addr, redirect_target);
        end
        exp_pc = redirect_target; since = 0;
      end
    end
    redirect_valid = 1'b0;
  endtask

  task automatic test_misalign();
    int n;
    apply_reset(1'b1); wait_valid(n);
    compared++;
    if (instr_valid !== 1'b1) begin mismatched++; $display("FAIL mis_timeout: got valid=%b expected 1", instr_valid); end
    for (int i = 0; i < 10; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
        redirect_valid = (i == 2 || i == 6);
        redirect_target = (i == 2) ? 32'h0000_0102 : 32'h0000_0200;
        #1;
      end
      if (i == 2) begin
        compared++;
        if ({imem_req, misalign_err} !== 2'b00) begin
          mismatched++; $display("FAIL mis_no_req: got req=%b err=%b expected 0 0", imem_req, misalign_err);
        end
      end
      if (i > 2) begin
        compared++;
        if ({misalign_err, imem_req, instr_valid} !== 3'b100) begin
          mismatched++; $display("FAIL mis_halt: got err/req/valid=%b expected 100", {misalign_err, imem_req, instr_valid});
        end
        $display("[%0t] halted cycle %0d err=%b", $time, i, misalign_err);
      end
    end
    redirect_valid = 1'b0;
    rst = 1'b1; #2;
    compared++;
    if (misalign_err !== 1'b0) begin mismatched++; $display("FAIL mis_clear: got err=%b expected 0", misalign_err); end
  endtask

  task automatic test_rst_mid_stall();
    logic [3*W+3:0] got, want;
    int n;
    apply_reset(1'b1); wait_valid(n);
    for (int i = 1; i < 6; i++) begin @(posedge clk); #1; instr_ready = (i < 2); #1; end
    #3 rst = 1'b1; #1;
    got  = {imem_req, imem_addr, instr_valid, instr_out, pc_out, pred_taken, misalign_err};
    want = {1'b0, RST_PC, 1'b0, NOP, RST_PC, 1'b0, 1'b0};
    compared++;
    if (got !== want) begin mismatched++; $display("FAIL rst_mid_stall: got %h expected %h", got, want); end
    @(posedge clk); #1; rst = 1'b0; instr_ready = 1'b1;
    wait_valid(n);
    compared++;
    if ({instr_valid, pc_out, instr_out} !== {1'b1, RST_PC, mem_word(RST_PC)} || n != 3) begin
      mismatched++; $display("FAIL rst_restart: got v=%b pc=%h after %0d cycles expected pc=%h after 3", instr_valid, pc_out, n, RST_PC);
    end
  endtask

  task automatic test_jal();
    logic [W-1:0] want_pc [5];
    logic         want_pred [5];
    int           n;
    int           got;
`ifdef FETCH_STATIC_PREDICT_EN
    want_pc = '{32'h0, 32'h4, 32'h8, 32'h48, 32'h4C};
    want_pred = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
`else
    want_pc = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
    want_pred = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
    jal_on = 1'b1;
    apply_reset(1'b1); wait_valid(n);
    got = 0;
    for (int i = 0; i < 14 && got < 5; i++) begin
      if (i > 0) begin @(posedge clk); #2; end
      if (instr_valid && instr_ready) begin
        compared++;
        if ({pc_out, pred_taken, instr_out} !== {want_pc[got], want_pred[got], mem_word(want_pc[got])}) begin
          mismatched++; $display("FAIL jal_seq: got pc=%h pred=%b instr=%h expected pc=%h pred=%b", pc_out, pred_taken, instr_out, want_pc[got], want_pred[got]);
        end
        $display("[%0t] jal-test accept pc=%h pred=%b instr=%h", $time, pc_out, pred_taken, instr_out);
        got++;
      end
    end
    compared++;
    if (got != 5) begin mismatched++; $display("FAIL jal_count: got %0d delivered expected 5", got); end
    jal_on = 1'b0;
  endtask

  task automatic test_random();
    int n;
    int since;
    apply_reset(1'b1); wait_valid(n);
    compared++;
    if (instr_valid !== 1'b1) begin mismatched++; $display("FAIL rand_timeout: got valid=%b expected 1", instr_valid); end
    exp_pc = RST_PC; since = 1;
    for (int i = 0; i < 400; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
        instr_ready = ($urandom_range(0, 3) != 0);
        redirect_valid = ($urandom_range(0, 19) == 0);
        redirect_target = $urandom() & 32'hFFFF_FFFC;
        #1;
      end
      since++;
      if (since == 1) begin
        compared++;
        if (instr_valid !== 1'b0) begin mismatched++; $display("FAIL rand_bubble: got valid=%b expected 0", instr_valid); end
      end else begin
        compared++;
        if (instr_valid !== 1'b1) begin mismatched++; $display("FAIL rand_gap: got valid=%b expected 1", instr_valid); end
      end
      if (instr_valid && instr_ready) begin
        compared++;
        if ({pc_out, instr_out, pred_taken} !== {exp_pc, mem_word(exp_pc), 1'b0}) begin
          mismatched++; $display("FAIL rand_order: got pc=%h instr=%h pred=%b expected pc=%h", pc_out, instr_out, pred_taken, exp_pc);
        end
        $display("[%0t] random accept pc=%h instr=%h", $time, pc_out, instr_out);
        exp_pc += 4;
      end
      if (redirect_valid) begin
        compared++;
        if ({imem_req, imem_addr} !== {1'b1, redirect_target}) begin
          mismatched++; $display("FAIL rand_redir_req: got req=%b addr=%h expected req=1 addr=%h", imem_req, imem_addr, redirect_target);
        end
        exp_pc = redirect_target; since = 0;
      end
    end
    redirect_valid = 1'b0; instr_ready = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_misalign();
    test_rst_mid_stall();
    test_jal();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
